uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It oversamples the serial line, detects and validates the start bit, and shifts in DATA_WIDTH bits LSB-first. It then checks the stop bit and pulses ld_data so the RX output register captures the assembled byte. It sits between the baud-tick generator and the RX output register.

Parameters:
DATA_WIDTH, 8, number of data bits per frame; also the width of the parallel output to the RX register.
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and at least 4.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx_serial  input  1  asynchronous serial line; idles high
Parallel_out  output  DATA_WIDTH  assembled frame data; drives the RX register Parallel_in
ld_data  output  1  one-clk load strobe to the RX register
rx_busy  output  1  high while a frame is in progress (any state other than IDLE)
framing_err  output  1  one-clk pulse when the stop bit is sampled low

Behaviour:
- Single clock domain: clk. rst is asynchronous, active-high.
- Reset values:
  - Parallel_out = 0, ld_data = 0, rx_busy = 0, framing_err = 0.
  - Synchronizer flops = 1.
  - tick_cnt = 0, bit_cnt = 0, state = IDLE.
- rx_serial passes through a 2-flop synchronizer. rx_s is the synchronized value; all decisions use rx_s.
- tick_cnt is $clog2(OVERSAMPLE) bits wide and counts only on clk edges where baud_tick=1.
- bit_cnt is $clog2(DATA_WIDTH)+1 bits wide.
- State IDLE:
  - rx_s=0 -> START, tick_cnt=0.
  - No baud_tick is needed to leave IDLE.
- State START (midpoint check):
  - On baud_tick with tick_cnt==OVERSAMPLE/2-1: if rx_s=0 -> DATA with tick_cnt=0, bit_cnt=0; if rx_s=1 (glitch) -> IDLE, no error flagged.
  - Otherwise tick_cnt increments on each baud_tick.
- State DATA:
  - On baud_tick with tick_cnt==OVERSAMPLE-1: shift rx_s into the shift register MSB, shifting right (so the first bit received lands at bit 0 after DATA_WIDTH shifts); bit_cnt increments; tick_cnt=0.
  - When the DATA_WIDTH-th bit has been captured -> STOP.
- State STOP:
  - On baud_tick with tick_cnt==OVERSAMPLE-1: rx_s=1 -> LOAD; rx_s=0 -> framing_err=1 for one clk, then IDLE.
  - On a framing error, Parallel_out is not updated and ld_data is not asserted.
- State LOAD:
  - Lasts one clk: Parallel_out holds the shift register, ld_data=1.
  - Next clk -> IDLE with ld_data=0.
  - Parallel_out holds its value until the next successful frame.
- Latency: ld_data rises 1 clk after the stop-bit sample edge. Parallel_out is valid on the same cycle that ld_data is high.
- Back-to-back frames: a start bit arriving right after LOAD is detected in IDLE. The minimum gap of one clk is acceptable because the stop bit is sampled at mid-bit.
- A baud_tick pulse while in LOAD is ignored.
- rx_busy is combinational from state: state != IDLE.
- Reset mid-frame returns everything to the reset values immediately. A partial frame never produces ld_data.
- Line held low (break): start is accepted, data bits are all 0, stop is 0 -> framing_err. The block then re-enters START each time it sees rx_s=0 in IDLE, giving one framing_err per frame time.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams: IDLE, START, DATA, STOP, LOAD (3-bit);
  - default DATA_WIDTH and OVERSAMPLE constants, shared with the TX side and the baud generator.
- One sub-module: uart_sync2, a 2-flop synchronizer with a reset value parameter (here 1). It is reusable for other async inputs.

Test Plan:
- Frame 0xA5, OVERSAMPLE=16, clean line -> bits 1,0,1,0,0,1,0,1 on the wire. Response: ld_data pulses once, Parallel_out=8'hA5, framing_err stays 0, rx_busy high for about 10 bit periods.
- Start glitch, rx_serial low for 4 ticks then high -> returns to IDLE at mid-start. No ld_data, no framing_err, Parallel_out unchanged.
- Frame 0x3C with stop bit forced 0 -> framing_err pulses once, ld_data stays 0, Parallel_out keeps the previous value (0xA5).
- Back-to-back frames 0x00 then 0xFF with a 1-bit stop and no idle gap -> two ld_data pulses, outputs 8'h00 then 8'hFF.
- rst asserted during bit 4 of frame 0x5A -> all outputs go to 0 at once. No ld_data. The next clean frame 0x81 loads correctly.
- baud_tick held low for 1000 clks with rx_serial=0 -> state stays START, no output changes.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    LOAD  = ST_LOAD
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous input
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - oversampling UART receive sequencer
// Validates the start bit at mid-bit, shifts data LSB-first, checks stop, strobes ld_data.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] Parallel_out,
  output logic                  ld_data,
  output logic                  rx_busy,
  output logic                  framing_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  rx_state_t             r_state;
  rx_state_t             w_next_state;
  logic [TW-1:0]         r_tick_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_parallel;
  logic                  r_ferr;
  logic                  w_rx_s;
  logic                  w_mid_hit;
  logic                  w_end_hit;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (rx_serial),
    .o_q   (w_rx_s)
  );

  assign w_mid_hit = baud_tick && (r_tick_cnt == TICK_MID);
  assign w_end_hit = baud_tick && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_rx_s) w_next_state = START;
      // A high line at mid-start is a glitch: drop back silently.
      START:   if (w_mid_hit) w_next_state = w_rx_s ? IDLE : DATA;
      DATA:    if (w_end_hit && (r_bit_cnt == BIT_LAST)) w_next_state = STOP;
      STOP:    if (w_end_hit) w_next_state = w_rx_s ? LOAD : IDLE;
      LOAD:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parallel <= '0;
      r_ferr     <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      case (r_state)
        IDLE: r_tick_cnt <= '0;
        START: begin
          if (w_mid_hit) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_end_hit) begin
            r_shift    <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_tick_cnt <= '0;
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_end_hit) begin
            r_tick_cnt <= '0;
            // Output register only moves on a good stop bit.
            if (w_rx_s) begin
              r_parallel <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else if (baud_tick) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Parallel_out = r_parallel;
  assign ld_data      = (r_state == LOAD);
  assign rx_busy      = (r_state != IDLE);
  assign framing_err  = r_ferr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 32;  // 16 ticks per bit, one tick every 2 clks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] Parallel_out;
  logic       ld_data;
  logic       rx_busy;
  logic       framing_err;

  logic tick_en = 1'b1;
  logic tick_phase = 1'b0;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int ferr_cnt = 0;
  int wide_cnt = 0;
  logic prev_ld = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap_bits;
    int         exp_ld;
    int         exp_fe;
    logic [7:0] exp_pout;
  } vec_t;

  vec_t vecs [4];

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .rx_serial    (rx_serial),
    .Parallel_out (Parallel_out),
    .ld_data      (ld_data),
    .rx_busy      (rx_busy),
    .framing_err  (framing_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      tick_phase = ~tick_phase;
      baud_tick  = tick_en & tick_phase;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ld_data) begin
        ld_cnt++;
        if (prev_ld) wide_cnt++;
      end
      if (framing_err) begin
        ferr_cnt++;
        if (prev_fe) wide_cnt++;
      end
      prev_ld = ld_data;
      prev_fe = framing_err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output logic busy_mid);
    busy_mid = 1'b0;
    rx_serial = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      if (i == 3) begin
        wait_clks(BIT_CLKS / 2);
        busy_mid = rx_busy;
        wait_clks(BIT_CLKS / 2);
      end else begin
        wait_clks(BIT_CLKS);
      end
    end
    if (stop) begin
      rx_serial = 1'b1;
      wait_clks(BIT_CLKS);
    end else begin
      // Low across the stop sample point, then a full idle bit.
      rx_serial = 1'b0;
      wait_clks(24);
      rx_serial = 1'b1;
      wait_clks(40);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                           input int gap, input int exp_ld, input int exp_fe,
                           input logic [7:0] exp_po);
    int ld0;
    int fe0;
    logic bm;
    ld0 = ld_cnt;
    fe0 = ferr_cnt;
    send_frame(d, stop, bm);
    rx_serial = 1'b1;
    wait_clks(gap * BIT_CLKS);
    #1;
    check({tag, " ld_pulses"}, 32'(ld_cnt - ld0), 32'(exp_ld));
    check({tag, " ferr_pulses"}, 32'(ferr_cnt - fe0), 32'(exp_fe));
    check({tag, " parallel_out"}, 32'(Parallel_out), 32'(exp_po));
    check({tag, " busy_mid"}, 32'(bm), 32'd1);
    check({tag, " busy_end"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int ld0;
    int fe0;
    logic [7:0] rd;
    logic rs;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap_bits: 1, exp_ld: 1, exp_fe: 0, exp_pout: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, gap_bits: 0, exp_ld: 0, exp_fe: 1, exp_pout: 8'hA5};
    vecs[2] = '{data: 8'h00, stop: 1'b1, gap_bits: 0, exp_ld: 1, exp_fe: 0, exp_pout: 8'h00};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, gap_bits: 1, exp_ld: 1, exp_fe: 0, exp_pout: 8'hFF};

    wait_clks(3);
    #1;
    check("reset parallel_out", 32'(Parallel_out), 32'h0);
    check("reset ld_data", 32'(ld_data), 32'h0);
    check("reset rx_busy", 32'(rx_busy), 32'h0);
    check("reset framing_err", 32'(framing_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_clks(BIT_CLKS);

    for (int v = 0; v < 4; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].stop, vecs[v].gap_bits,
                vecs[v].exp_ld, vecs[v].exp_fe, vecs[v].exp_pout);
    end
    last_good = 8'hFF;

    // Start glitch: low for 4 ticks only.
    ld0 = ld_cnt;
    fe0 = ferr_cnt;
    rx_serial = 1'b0;
    wait_clks(8);
    #1;
    check("glitch busy_during", 32'(rx_busy), 32'd1);
    rx_serial = 1'b1;
    wait_clks(40);
    #1;
    check("glitch ld_pulses", 32'(ld_cnt - ld0), 32'd0);
    check("glitch ferr_pulses", 32'(ferr_cnt - fe0), 32'd0);
    check("glitch parallel_out", 32'(Parallel_out), 32'(last_good));
    check("glitch busy_end", 32'(rx_busy), 32'd0);

    // Reset during data bit 4 of 0x5A.
    ld0 = ld_cnt;
    rd = 8'h5A;
    rx_serial = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx_serial = rd[i];
      wait_clks(BIT_CLKS);
    end
    rx_serial = rd[4];
    wait_clks(10);
    #2;
    rst = 1'b1;
    #1;
    check("midrst parallel_out", 32'(Parallel_out), 32'h0);
    check("midrst ld_data", 32'(ld_data), 32'h0);
    check("midrst rx_busy", 32'(rx_busy), 32'h0);
    check("midrst framing_err", 32'(framing_err), 32'h0);
    rx_serial = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2 * BIT_CLKS);
    #1;
    check("midrst ld_pulses", 32'(ld_cnt - ld0), 32'd0);
    last_good = 8'h00;
    run_frame("after_rst", 8'h81, 1'b1, 1, 1, 0, 8'h81);
    last_good = 8'h81;

    // No baud ticks with the line low: stuck in START, nothing else moves.
    ld0 = ld_cnt;
    fe0 = ferr_cnt;
    tick_en = 1'b0;
    wait_clks(2);
    rx_serial = 1'b0;
    wait_clks(1000);
    #1;
    check("notick busy", 32'(rx_busy), 32'd1);
    check("notick ld_pulses", 32'(ld_cnt - ld0), 32'd0);
    check("notick ferr_pulses", 32'(ferr_cnt - fe0), 32'd0);
    check("notick parallel_out", 32'(Parallel_out), 32'(last_good));
    rx_serial = 1'b1;
    wait_clks(4);
    tick_en = 1'b1;
    wait_clks(40);
    #1;
    check("notick recover_idle", 32'(rx_busy), 32'd0);

    // Random frames against the frame-level model.
    for (int n = 0; n < 16; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      if (rs) last_good = rd;
      run_frame($sformatf("rand%0d", n), rd, rs, int'($urandom_range(0, 1)),
                rs ? 1 : 0, rs ? 0 : 1, last_good);
    end

    check("pulse_width_violations", 32'(wide_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
